// File: rtl/prefetch_fetcher_pkg.sv
// Shared types for the prefetching instruction fetcher: core phases, fetcher
// states and the queue entry layout at the default memory widths.
package fetcher_pkg;
  localparam int PMEM_ADDR_BITS = 8;
  localparam int PMEM_DATA_BITS = 16;

  localparam logic [2:0] CORE_IDLE   = 3'b000;
  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;
  localparam logic [2:0] CORE_DONE   = 3'b111;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } fetcher_state_t;

  typedef struct packed {
    logic [PMEM_ADDR_BITS-1:0] addr;
    logic [PMEM_DATA_BITS-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/prefetch_fetcher_queue.sv
// Circular FIFO of {addr, instr} entries with push, pop and whole-queue flush.
module fetch_queue
  import fetcher_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [AW-1:0]            i_addr,
  input  logic [DW-1:0]            i_instr,
  output logic                     o_head_vld,
  output logic [AW-1:0]            o_head_addr,
  output logic [DW-1:0]            o_head_instr,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] instr;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: r_cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= {i_addr, i_instr};
  end

  assign o_head_vld   = (r_cnt != '0);
  assign o_head_addr  = r_mem[r_rd].addr;
  assign o_head_instr = r_mem[r_rd].instr;
  assign o_count      = r_cnt;
endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction fetcher that runs ahead of the PC into a small queue, flushing
// and re-targeting whenever the requested PC is not at the queue head.
module prefetch_fetcher
  import fetcher_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int DEPTH                 = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             prefetch_en,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [$clog2(DEPTH):0]           queue_count
);
  localparam int AW = PROGRAM_MEM_ADDR_BITS;
  localparam int DW = PROGRAM_MEM_DATA_BITS;
  localparam int CW = $clog2(DEPTH) + 1;

  fetcher_state_t r_state, w_state_nxt;
  logic [AW-1:0]  r_fpc, r_req_addr;
  logic           r_inflight, r_discard;
  logic [DW-1:0]  r_instr;

  logic           w_head_vld;
  logic [AW-1:0]  w_head_addr;
  logic [DW-1:0]  w_head_instr;
  logic [CW-1:0]  w_count, w_cnt_eff, w_limit;
  logic [AW-1:0]  w_fpc_src;
  logic           w_resp, w_head_match, w_lookup, w_hit, w_pending, w_miss;
  logic           w_pop, w_push, w_issue, w_core_active;

  assign w_resp        = r_inflight && mem_read_ready;
  assign w_head_match  = w_head_vld && (w_head_addr == current_pc);
  assign w_lookup      = (r_state == IDLE) && (core_state == CORE_FETCH);
  assign w_hit         = w_lookup && w_head_match;
  // A request already being dropped can never satisfy the PC, so it is not pending.
  assign w_pending     = w_lookup && !w_head_vld && r_inflight && !r_discard &&
                         (r_req_addr == current_pc);
  assign w_miss        = w_lookup && !w_hit && !w_pending;
  assign w_pop         = w_hit || ((r_state == FETCHING) && w_head_match);
  assign w_push        = w_resp && !r_discard && !w_miss;

  // On a miss the flush and the re-targeted issue happen on the same edge.
  assign w_core_active = (core_state != CORE_IDLE) && (core_state != CORE_DONE);
  assign w_limit       = prefetch_en ? CW'(DEPTH) : CW'(1);
  assign w_cnt_eff     = w_miss ? '0 : w_count;
  assign w_fpc_src     = w_miss ? current_pc : r_fpc;
  assign w_issue       = !r_inflight && w_core_active && (w_cnt_eff < w_limit);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_hit) w_state_nxt = FETCHED;
                else if (w_lookup) w_state_nxt = FETCHING;
      FETCHING: if (w_head_match) w_state_nxt = FETCHED;
      FETCHED:  if (core_state == CORE_DECODE) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_fpc      <= '0;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
      r_instr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_instr <= w_head_instr;
      if (w_issue) begin
        r_inflight <= 1'b1;
        r_req_addr <= w_fpc_src;
        r_fpc      <= w_fpc_src + 1'b1;
      end else begin
        if (w_resp) r_inflight <= 1'b0;
        if (w_miss) r_fpc <= current_pc;
      end
      if (w_resp) r_discard <= 1'b0;
      else if (w_miss && r_inflight) r_discard <= 1'b1;
    end
  end

  fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (w_miss),
    .i_addr       (r_req_addr),
    .i_instr      (mem_read_data),
    .o_head_vld   (w_head_vld),
    .o_head_addr  (w_head_addr),
    .o_head_instr (w_head_instr),
    .o_count      (w_count)
  );

  assign mem_read_valid   = r_inflight;
  assign mem_read_address = r_req_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;
  assign queue_count      = w_count;
endmodule
